regfile_wb_ctrl: RTL and testbench

- Write-back controller directly upstream of the CPU register file; it owns the file's single write port (Wen/Rd/BusW).
- Arbitrates between the single-cycle ALU result path and a long-latency result path (load/mul-div) and holds a losing ALU result in a 1-entry buffer.
- Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards against results not yet written.

---
 rtl/regfile_wb_ctrl_pkg.sv | 21 ++
 rtl/regfile_wb_ctrl_wb_skid_buf.sv | 53 +++++
 rtl/regfile_wb_ctrl.sv | 137 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared CPU definitions for the write-back path: widths, the x0 index,
// the write-request record and the register file's all-zero word.
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package regfile_wb_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_wb_skid_buf.sv
// One-entry holding buffer for an ALU result that lost the write port.
// Accepts only while empty; the held entry is offered downstream until taken.
module wb_skid_buf
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_rd,
  output logic [XLEN-1:0] out_data
);

  logic            r_full;
  logic [RW-1:0]   r_rd;
  logic [XLEN-1:0] r_data;
  logic            w_push;
  logic            w_pop;

  assign in_ready  = ~r_full;
  assign w_push    = in_valid & ~r_full;
  assign w_pop     = out_ready & r_full;
  assign out_valid = r_full;
  assign out_rd    = r_rd;
  assign out_data  = r_data;

  // Occupancy flag: the only control state, cleared by reset to drop the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (w_push) begin
      r_full <= 1'b1;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end
  end

  // Payload capture; contents are meaningless while the flag is clear
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd   <= in_rd;
      r_data <= in_data;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller in front of the register file's single write port.
// Arbitrates ALU vs long-latency results, buffers one losing ALU result and
// keeps the per-register busy scoreboard used by decode for RAW/WAW stalls.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter bit LU_PRIO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  output logic                     issue_ready,
  input  logic [$clog2(NREG)-1:0]  rs1_addr,
  input  logic [$clog2(NREG)-1:0]  rs2_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic                     alu_valid,
  input  logic [$clog2(NREG)-1:0]  alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     lu_valid,
  input  logic [$clog2(NREG)-1:0]  lu_rd,
  input  logic [XLEN-1:0]          lu_data,
  output logic                     lu_ready,
  output logic                     wb_en,
  output logic [$clog2(NREG)-1:0]  wb_rd,
  output logic [XLEN-1:0]          wb_data
);

  localparam int RW = $clog2(NREG);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            r_wb_en;
  logic [RW-1:0]   r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic            w_buf_in_valid;
  logic            w_buf_in_ready;
  logic            w_buf_valid;
  logic [RW-1:0]   w_buf_rd;
  logic [XLEN-1:0] w_buf_data;

  logic            w_alu_src_valid;
  logic [RW-1:0]   w_alu_src_rd;
  logic [XLEN-1:0] w_alu_src_data;
  logic            w_lu_win;
  logic            w_alu_win;
  logic [RW-1:0]   w_win_rd;
  logic [XLEN-1:0] w_win_data;
  logic            w_wr;
  logic            w_issue_fire;

  // A held ALU result competes ahead of any new one so ordering is preserved.
  assign w_alu_src_valid = w_buf_valid | alu_valid;
  assign w_alu_src_rd    = w_buf_valid ? w_buf_rd   : alu_rd;
  assign w_alu_src_data  = w_buf_valid ? w_buf_data : alu_data;

  // Fixed-priority arbitration; the losing ALU side is parked, the losing
  // long-latency side is simply back-pressured.
  assign w_lu_win  = lu_valid & (LU_PRIO | ~w_alu_src_valid);
  assign w_alu_win = w_alu_src_valid & ~w_lu_win;

  assign w_win_rd   = w_lu_win ? lu_rd   : w_alu_src_rd;
  assign w_win_data = w_lu_win ? lu_data : w_alu_src_data;
  assign w_wr       = (w_lu_win | w_alu_win) & (w_win_rd != REG_ZERO);

  // New ALU result goes to the buffer only when the long-latency path took the port.
  assign w_buf_in_valid = alu_valid & w_lu_win;
  assign alu_ready      = w_buf_in_ready;
  assign lu_ready       = LU_PRIO | ~w_alu_src_valid;

  wb_skid_buf #(
    .XLEN (XLEN),
    .RW   (RW)
  ) u_alu_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_buf_in_valid),
    .in_ready  (w_buf_in_ready),
    .in_rd     (alu_rd),
    .in_data   (alu_data),
    .out_valid (w_buf_valid),
    .out_ready (w_alu_win),
    .out_rd    (w_buf_rd),
    .out_data  (w_buf_data)
  );

  assign issue_ready  = ~r_busy[issue_rd];
  assign w_issue_fire = issue_valid & issue_ready;
  assign rs1_busy     = r_busy[rs1_addr];
  assign rs2_busy     = r_busy[rs2_addr];

  // Scoreboard next state: write-back clears, issue sets afterwards so set wins; x0 never busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) begin
      w_busy_nxt[w_win_rd] = 1'b0;
    end
    if (w_issue_fire) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Write-port register: the file writes on the following negedge; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_wr;
      if (w_wr) begin
        r_wb_rd   <= w_win_rd;
        r_wb_data <= w_win_data;
      end
    end
  end

  assign wb_en   = r_wb_en;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: reset checks, a table of directed cycles,
// an asynchronous reset with the ALU buffer full, then random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_ctrl;

  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam bit LU_PRIO = 1'b1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .LU_PRIO (LU_PRIO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_ir;
    logic        e_rsb;
    logic        e_ar;
    logic        e_lr;
    logic        e_wen;
    logic [4:0]  e_wrd;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t        tbl[$];
  ent_t        m_buf[$];
  logic [31:0] m_busy;

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(int iv, int ird, int rs, int av, int ard, int ad,
                              int lv, int lrd, int ld, int e_ir, int e_rsb,
                              int e_ar, int e_lr, int e_wen, int e_wrd, int e_wd);
    vec_t v;
    v.iv = 1'(iv);   v.ird = 5'(ird);  v.rs = 5'(rs);
    v.av = 1'(av);   v.ard = 5'(ard);  v.ad = 32'(ad);
    v.lv = 1'(lv);   v.lrd = 5'(lrd);  v.ld = 32'(ld);
    v.e_ir = 1'(e_ir);   v.e_rsb = 1'(e_rsb);
    v.e_ar = 1'(e_ar);   v.e_lr = 1'(e_lr);
    v.e_wen = 1'(e_wen); v.e_wrd = 5'(e_wrd); v.e_wd = 32'(e_wd);
    return v;
  endfunction

  task automatic drive(input int iv, input int ird, input int r1, input int r2,
                       input int av, input int ard, input logic [31:0] ad,
                       input int lv, input int lrd, input logic [31:0] ld);
    issue_valid = 1'(iv);
    issue_rd    = 5'(ird);
    rs1_addr    = 5'(r1);
    rs2_addr    = 5'(r2);
    alu_valid   = 1'(av);
    alu_rd      = 5'(ard);
    alu_data    = ad;
    lu_valid    = 1'(lv);
    lu_rd       = 5'(lrd);
    lu_data     = ld;
  endtask

  initial begin
    logic        a_pend, l_pend, iv, e_ir, src_v, e_ar, e_lr, w_v;
    logic [4:0]  a_rd, l_rd, ird, r1, r2, w_rd;
    logic [31:0] a_data, l_data, w_d;

    // ---------------- reset with an ALU result pending
    rst_n = 1'b0;
    drive(0, 5, 5, 5, 1, 5, 32'h55, 0, 0, 0);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk1("rst wb_en", wb_en, 1'b0);
      chk32("rst wb_rd", 32'(wb_rd), 32'h0);
      chk32("rst wb_data", wb_data, 32'h0);
      chk1("rst issue_ready rd5", issue_ready, 1'b1);
      chk1("rst rs1_busy", rs1_busy, 1'b0);
      chk1("rst rs2_busy", rs2_busy, 1'b0);
    end
    rst_n = 1'b1;
    #3;
    chk1("post-rst alu_ready", alu_ready, 1'b1);
    @(posedge clk); #1;
    chk1("post-rst wb_en", wb_en, 1'b1);
    chk32("post-rst wb_rd", 32'(wb_rd), 32'd5);
    chk32("post-rst wb_data", wb_data, 32'h55);

    // ---------------- directed cycle table
    //           iv ird rs  av ard ad       lv lrd ld        ir rsb ar lr wen wrd wd
    tbl.push_back(mk(1, 3, 3,  0, 0, 0,       0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3,  1, 3, 'h1234,  0, 0, 0,       1, 1, 1, 1, 1, 3, 'h1234));
    tbl.push_back(mk(0, 0, 3,  0, 0, 0,       0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 8, 'h5555,  1, 7, 'hAAAA,  1, 0, 1, 1, 1, 7, 'hAAAA));
    tbl.push_back(mk(0, 0, 0,  1, 9, 'h0999,  0, 0, 0,       1, 0, 0, 1, 1, 8, 'h5555));
    tbl.push_back(mk(0, 0, 0,  1, 9, 'h0999,  0, 0, 0,       1, 0, 1, 1, 1, 9, 'h0999));
    tbl.push_back(mk(0, 0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 10, 10, 0, 0, 0,      0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 10, 10, 0, 0, 0,      0, 0, 0,       0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 10, 10, 0, 0, 0,      1, 10, 'hBEEF, 0, 1, 1, 1, 1, 10, 'hBEEF));
    tbl.push_back(mk(1, 10, 10, 0, 0, 0,      0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 10, 10, 0, 0, 0,      0, 0, 0,       0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 10, 10, 0, 0, 0,      1, 10, 'h1,    0, 1, 1, 1, 1, 10, 'h1));
    tbl.push_back(mk(0, 10, 10, 0, 0, 0,      0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 11, 11, 1, 11, 'h11,  0, 0, 0,       1, 0, 1, 1, 1, 11, 'h11));
    tbl.push_back(mk(0, 11, 11, 0, 0, 0,      0, 0, 0,       0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 11, 11, 0, 0, 0,      1, 11, 'h22,   0, 1, 1, 1, 1, 11, 'h22));
    tbl.push_back(mk(0, 11, 11, 0, 0, 0,      0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 'hFFFF,  0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0,       0, 0, 0,       1, 0, 1, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(int'(tbl[i].iv), int'(tbl[i].ird), int'(tbl[i].rs), int'(tbl[i].rs),
            int'(tbl[i].av), int'(tbl[i].ard), tbl[i].ad,
            int'(tbl[i].lv), int'(tbl[i].lrd), tbl[i].ld);
      #3;
      chk1($sformatf("v%0d issue_ready", i), issue_ready, tbl[i].e_ir);
      chk1($sformatf("v%0d rs1_busy", i), rs1_busy, tbl[i].e_rsb);
      chk1($sformatf("v%0d rs2_busy", i), rs2_busy, tbl[i].e_rsb);
      chk1($sformatf("v%0d alu_ready", i), alu_ready, tbl[i].e_ar);
      chk1($sformatf("v%0d lu_ready", i), lu_ready, tbl[i].e_lr);
      @(posedge clk); #1;
      chk1($sformatf("v%0d wb_en", i), wb_en, tbl[i].e_wen);
      if (tbl[i].e_wen) begin
        chk32($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(tbl[i].e_wrd));
        chk32($sformatf("v%0d wb_data", i), wb_data, tbl[i].e_wd);
      end
    end

    // ---------------- asynchronous reset with the ALU buffer full
    drive(1, 14, 14, 14, 0, 0, 0, 0, 0, 0);
    #3;
    chk1("arst issue14 ready", issue_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 14, 14, 1, 13, 32'hD13, 1, 12, 32'hC12);
    #3;
    chk1("arst conflict alu_ready", alu_ready, 1'b1);
    @(posedge clk); #1;
    chk32("arst lu wb_rd", 32'(wb_rd), 32'd12);
    chk32("arst lu wb_data", wb_data, 32'hC12);
    drive(0, 0, 14, 14, 0, 0, 0, 0, 0, 0);
    #1;
    chk1("arst buffer full alu_ready", alu_ready, 1'b0);
    chk1("arst rs1 busy14", rs1_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("arst wb_en", wb_en, 1'b0);
    chk32("arst wb_rd", 32'(wb_rd), 32'h0);
    chk32("arst wb_data", wb_data, 32'h0);
    chk1("arst buffer emptied", alu_ready, 1'b1);
    chk1("arst busy14 cleared", rs1_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("arst no stale write %0d", i), wb_en, 1'b0);
    end

    // ---------------- random traffic against the reference model
    m_busy = '0;
    a_pend = 1'b0; l_pend = 1'b0;
    a_rd = '0; l_rd = '0; a_data = '0; l_data = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend = 1'b1;
        a_rd   = 5'($urandom_range(0, 7));
        a_data = $urandom;
      end
      if (!l_pend && $urandom_range(0, 2) == 0) begin
        l_pend = 1'b1;
        l_rd   = 5'($urandom_range(0, 7));
        l_data = $urandom;
      end
      iv  = 1'($urandom_range(0, 1));
      ird = 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      drive(int'(iv), int'(ird), int'(r1), int'(r2), int'(a_pend), int'(a_rd), a_data,
            int'(l_pend), int'(l_rd), l_data);

      e_ir  = (ird == 5'd0) || !m_busy[ird];
      src_v = (m_buf.size() > 0) || a_pend;
      e_ar  = (m_buf.size() == 0);
      e_lr  = LU_PRIO || !src_v;
      #3;
      chk1($sformatf("rnd%0d issue_ready", c), issue_ready, e_ir);
      chk1($sformatf("rnd%0d rs1_busy", c), rs1_busy, m_busy[r1]);
      chk1($sformatf("rnd%0d rs2_busy", c), rs2_busy, m_busy[r2]);
      chk1($sformatf("rnd%0d alu_ready", c), alu_ready, e_ar);
      chk1($sformatf("rnd%0d lu_ready", c), lu_ready, e_lr);

      w_v = 1'b0; w_rd = '0; w_d = '0;
      if (l_pend && e_lr) begin
        w_v = 1'b1; w_rd = l_rd; w_d = l_data; l_pend = 1'b0;
        if (a_pend && e_ar) begin
          m_buf.push_back('{rd: a_rd, data: a_data});
          a_pend = 1'b0;
        end
      end else if (m_buf.size() > 0) begin
        w_v = 1'b1; w_rd = m_buf[0].rd; w_d = m_buf[0].data;
        m_buf.pop_front();
      end else if (a_pend) begin
        w_v = 1'b1; w_rd = a_rd; w_d = a_data; a_pend = 1'b0;
      end
      if (w_v) m_busy[w_rd] = 1'b0;
      if (iv && e_ir && ird != 5'd0) m_busy[ird] = 1'b1;

      @(posedge clk); #1;
      chk1($sformatf("rnd%0d wb_en", c), wb_en, w_v && (w_rd != 5'd0));
      if (w_v && (w_rd != 5'd0)) begin
        chk32($sformatf("rnd%0d wb_rd", c), 32'(wb_rd), 32'(w_rd));
        chk32($sformatf("rnd%0d wb_data", c), wb_data, w_d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
